// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - command encodings and word layout shared by spi_ram, the SPI slave and benches
package spi_ram_pkg;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_ram_cmd_e;

endpackage

// File: rtl/spi_ram_array.sv
// rtl/spi_ram_array.sv - single-port byte storage, synchronous write, registered read
//
// Ports:
//   clk    system clock
//   we     write enable; wdata stored at waddr on the rising edge
//   waddr  write address (caller guarantees waddr < MEM_DEPTH when we is high)
//   wdata  write byte
//   re     read enable; rdata loads mem[raddr] on the rising edge, holds otherwise
//   raddr  read address (caller guarantees raddr < MEM_DEPTH when re is high)
//   rdata  registered read byte
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // No reset on the array so it maps onto block RAM.
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[IDX_W'(waddr)] <= wdata;
        end
        if (re) begin
            rdata <= mem[IDX_W'(raddr)];
        end
    end

endmodule

// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - command-driven byte RAM behind the SPI slave
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (pointers and pulses only; storage kept)
//   din       10-bit word from SPI slave: [9:8] command, [7:0] payload
//   rx_valid  one-cycle qualifier for din
//   dout      read byte returned to the SPI slave
//   tx_valid  one-cycle qualifier for dout, one cycle after an RD_DATA word
//   addr_err  one-cycle pulse on a data access at or beyond MEM_DEPTH
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              addr_err
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    spi_ram_cmd_e          cmd;
    logic [ADDR_SIZE-1:0]  payload_addr;
    logic [ADDR_SIZE-1:0]  wr_addr;
    logic [ADDR_SIZE-1:0]  rd_addr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_W-1:0]     mem_rdata;
    // Forces dout to zero after reset and after an out-of-range read, so the
    // array's read register never needs a reset of its own.
    logic                  rd_zero;

    assign cmd          = spi_ram_cmd_e'(din[9:8]);
    assign payload_addr = ADDR_SIZE'(din[7:0]);

    // Every pointer value is legal when the storage spans the whole address
    // space, so the comparator only exists for short memories.
    generate
        if (MEM_DEPTH < (1 << ADDR_SIZE)) begin : g_range_check
            assign wr_ok = (32'(wr_addr) < MEM_DEPTH);
            assign rd_ok = (32'(rd_addr) < MEM_DEPTH);
        end else begin : g_no_range_check
            assign wr_ok = 1'b1;
            assign rd_ok = 1'b1;
        end
    endgenerate

    function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + ADDR_SIZE'(1);
    endfunction

    assign mem_we = rx_valid && (cmd == CMD_WR_DATA) && wr_ok;
    assign mem_re = rx_valid && (cmd == CMD_RD_DATA) && rd_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            tx_valid <= 1'b0;
            addr_err <= 1'b0;
            rd_zero  <= 1'b1;
        end else begin
            tx_valid <= 1'b0;
            addr_err <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= payload_addr;
                    CMD_WR_DATA: begin
                        addr_err <= !wr_ok;
                        if (AUTO_INC != 0) begin
                            wr_addr <= next_ptr(wr_addr);
                        end
                    end
                    CMD_RD_ADDR: rd_addr <= payload_addr;
                    CMD_RD_DATA: begin
                        tx_valid <= 1'b1;
                        addr_err <= !rd_ok;
                        rd_zero  <= !rd_ok;
                        if (AUTO_INC != 0) begin
                            rd_addr <= next_ptr(rd_addr);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (din[7:0]),
        .re    (mem_re),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    assign dout = rd_zero ? '0 : mem_rdata;

endmodule

// File: tb/tb_spi_ram.sv
// tb/tb_spi_ram.sv - directed self-checking bench for spi_ram
module tb_spi_ram;
    import spi_ram_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic [2:0] rxv;

    logic [7:0] dout_a, dout_b, dout_c;
    logic       tx_a, tx_b, tx_c;
    logic       err_a, err_b, err_c;

    int total;
    int passed;

    // a: default 256-deep, no auto-increment
    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[0]),
        .dout(dout_a), .tx_valid(tx_a), .addr_err(err_a)
    );
    // b: 4-deep with auto-increment and wrap
    spi_ram #(.MEM_DEPTH(4), .ADDR_SIZE(8), .AUTO_INC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[1]),
        .dout(dout_b), .tx_valid(tx_b), .addr_err(err_b)
    );
    // c: 200-deep, exercises out-of-range detection
    spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[2]),
        .dout(dout_c), .tx_valid(tx_c), .addr_err(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Presents one word for one cycle; returns at the negedge where the
    // registered response is visible.
    task automatic send(input int sel, input logic [1:0] cmd, input logic [7:0] pl);
        @(negedge clk);
        din      = {cmd, pl};
        rxv      = '0;
        rxv[sel] = 1'b1;
        @(negedge clk);
        rxv      = '0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        din    = '0;
        rxv    = '0;
        repeat (2) @(negedge clk);
        chk("rst_dout_a", dout_a, 8'h00);
        chk("rst_tx_a", {7'd0, tx_a}, 8'd0);
        chk("rst_err_a", {7'd0, err_a}, 8'd0);
        chk("rst_dout_c", dout_c, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Pulse timing before anything is written
        send(0, CMD_RD_ADDR, 8'h10);
        chk("rdaddr_no_tx", {7'd0, tx_a}, 8'd0);
        send(0, CMD_RD_DATA, 8'h00);
        chk("first_rd_tx", {7'd0, tx_a}, 8'd1);
        chk("first_rd_err", {7'd0, err_a}, 8'd0);
        @(negedge clk);
        chk("first_rd_tx_drop", {7'd0, tx_a}, 8'd0);

        // Write then read back 0x10
        send(0, CMD_WR_ADDR, 8'h10);
        send(0, CMD_WR_DATA, 8'h3C);
        send(0, CMD_RD_DATA, 8'h00);
        chk("rd10_dout", dout_a, 8'h3C);

        // 0x2A <- 0xC3
        send(0, CMD_WR_ADDR, 8'h2A);
        send(0, CMD_WR_DATA, 8'hC3);
        chk("wr2a_err", {7'd0, err_a}, 8'd0);
        send(0, CMD_RD_ADDR, 8'h2A);
        send(0, CMD_RD_DATA, 8'h5E);
        chk("rd2a_dout", dout_a, 8'hC3);
        chk("rd2a_tx", {7'd0, tx_a}, 8'd1);
        chk("rd2a_err", {7'd0, err_a}, 8'd0);
        @(negedge clk);
        chk("rd2a_tx_drop", {7'd0, tx_a}, 8'd0);
        chk("rd2a_dout_hold", dout_a, 8'hC3);

        // Pointer independence
        send(0, CMD_WR_ADDR, 8'h07);
        send(0, CMD_WR_DATA, 8'h99);
        send(0, CMD_WR_ADDR, 8'h05);
        send(0, CMD_RD_ADDR, 8'h07);
        send(0, CMD_WR_DATA, 8'h11);
        send(0, CMD_RD_DATA, 8'h00);
        chk("indep_rd07", dout_a, 8'h99);
        send(0, CMD_RD_ADDR, 8'h05);
        send(0, CMD_RD_DATA, 8'h00);
        chk("indep_rd05", dout_a, 8'h11);

        // Read-after-write on consecutive words
        send(0, CMD_WR_ADDR, 8'h30);
        send(0, CMD_RD_ADDR, 8'h30);
        send(0, CMD_WR_DATA, 8'h4E);
        send(0, CMD_RD_DATA, 8'h00);
        chk("raw_dout", dout_a, 8'h4E);

        // Auto-increment with wrap on the 4-deep instance
        send(1, CMD_WR_ADDR, 8'h03);
        send(1, CMD_WR_DATA, 8'hAA);
        send(1, CMD_WR_DATA, 8'hBB);
        chk("wrap_wr_err", {7'd0, err_b}, 8'd0);
        send(1, CMD_RD_ADDR, 8'h03);
        @(negedge clk);
        din    = {CMD_RD_DATA, 8'h00};
        rxv[1] = 1'b1;
        @(negedge clk);
        chk("b2b_tx0", {7'd0, tx_b}, 8'd1);
        chk("b2b_dout0", dout_b, 8'hAA);
        @(negedge clk);
        rxv = '0;
        chk("b2b_tx1", {7'd0, tx_b}, 8'd1);
        chk("b2b_dout1", dout_b, 8'hBB);
        @(negedge clk);
        chk("b2b_tx_drop", {7'd0, tx_b}, 8'd0);

        // Out-of-range on the 200-deep instance
        send(2, CMD_WR_ADDR, 8'h70);
        send(2, CMD_WR_DATA, 8'h12);
        chk("oor_inrange_err", {7'd0, err_c}, 8'd0);
        send(2, CMD_WR_ADDR, 8'hF0);
        send(2, CMD_WR_DATA, 8'h55);
        chk("oor_wr_err", {7'd0, err_c}, 8'd1);
        @(negedge clk);
        chk("oor_wr_err_drop", {7'd0, err_c}, 8'd0);
        send(2, CMD_RD_ADDR, 8'h70);
        send(2, CMD_RD_DATA, 8'h00);
        chk("oor_alias_intact", dout_c, 8'h12);
        send(2, CMD_RD_ADDR, 8'hF0);
        send(2, CMD_RD_DATA, 8'h00);
        chk("oor_rd_dout", dout_c, 8'h00);
        chk("oor_rd_tx", {7'd0, tx_c}, 8'd1);
        chk("oor_rd_err", {7'd0, err_c}, 8'd1);

        // Reset in the middle of a read response
        send(0, CMD_WR_ADDR, 8'h01);
        send(0, CMD_WR_DATA, 8'h77);
        send(0, CMD_RD_ADDR, 8'h2A);
        send(0, CMD_RD_DATA, 8'h00);
        chk("pre_rst_tx", {7'd0, tx_a}, 8'd1);
        chk("pre_rst_dout", dout_a, 8'hC3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {7'd0, tx_a}, 8'd0);
        chk("async_rst_dout", dout_a, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, CMD_WR_DATA, 8'h5A);
        send(0, CMD_RD_DATA, 8'h00);
        chk("post_rst_ptr0", dout_a, 8'h5A);
        send(0, CMD_RD_ADDR, 8'h01);
        send(0, CMD_RD_DATA, 8'h00);
        chk("post_rst_retained", dout_a, 8'h77);
        chk("post_rst_tx", {7'd0, tx_a}, 8'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_ram.md
Name: spi_ram

Overview:
- Single-port RAM stage directly downstream of the SPI slave.
- Consumes each 10-bit word the SPI slave assembles (din, qualified by rx_valid) as a command plus payload.
- Maintains independent write and read address pointers and performs byte writes to storage.
- Returns read bytes to the SPI slave on dout with a one-cycle tx_valid pulse, which the SPI slave shifts out on MISO.

Parameters:
- MEM_DEPTH, 256: number of 8-bit words in storage.
- ADDR_SIZE, 8: width of address pointers and of the payload used as an address.
- AUTO_INC, 0: 1 = pointer post-increments after each data access, wrapping MEM_DEPTH-1 -> 0; 0 = pointers change only via address commands.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  10  command word from SPI slave; [9:8] = cmd, [7:0] = payload.
- rx_valid  input  1  din qualifier, one-cycle pulse per word.
- dout  output  8  read data to SPI slave.
- tx_valid  output  1  dout qualifier, one-cycle pulse.
- addr_err  output  1  one-cycle pulse on a data access to an address >= MEM_DEPTH.

Behaviour:
- Reset (asynchronous, rst_n low):
  - wr_addr = 0, rd_addr = 0, dout = 8'h00, tx_valid = 0, addr_err = 0.
  - Storage contents are not cleared; they are preserved across reset and undefined after power-up.
- Command decode: only evaluated on a cycle with rx_valid = 1. When rx_valid = 0 there is no state change, tx_valid = 0, addr_err = 0, and dout holds its value.
- cmd 2'b00 (WR_ADDR): wr_addr <= payload[ADDR_SIZE-1:0].
- cmd 2'b01 (WR_DATA):
  - If wr_addr < MEM_DEPTH: mem[wr_addr] <= payload.
  - Otherwise: no write, addr_err = 1 next cycle.
  - If AUTO_INC = 1: wr_addr advances after the access, wrapping to 0 after MEM_DEPTH-1.
- cmd 2'b10 (RD_ADDR): rd_addr <= payload. No tx_valid.
- cmd 2'b11 (RD_DATA):
  - Payload is ignored (dummy).
  - If rd_addr < MEM_DEPTH: dout <= mem[rd_addr]. Otherwise: dout <= 8'h00 and addr_err = 1.
  - tx_valid = 1 for exactly the cycle following the rx_valid cycle (latency 1).
  - If AUTO_INC = 1: rd_addr advances with wrap.
  - RD_DATA with no prior RD_ADDR reads from rd_addr = 0 (reset value).
- Pointer independence: wr_addr and rd_addr are separate. An address command never affects the other pointer.
- Read-after-write: a WR_DATA followed by RD_DATA to the same address on the next rx_valid returns the new byte. Storage is updated at the end of the WR_DATA cycle.
- Back-to-back rx_valid on consecutive cycles: each word is processed independently. Two consecutive RD_DATA words give tx_valid high for 2 cycles with the two bytes.
- Out-of-range detection is needed only when MEM_DEPTH < 2^ADDR_SIZE. Otherwise addr_err is tied 0 by construction.
- Reset asserted mid-stream:
  - A write in the same edge as reset assertion is not required to complete.
  - tx_valid drops immediately (asynchronously).
  - Words arriving while rst_n is low are discarded.
- Storage: synchronous write and registered synchronous read, inferable as block RAM. No reset on the array.

Decomposition:
- spi_ram_pkg holds the command encodings CMD_WR_ADDR = 2'b00, CMD_WR_DATA = 2'b01, CMD_RD_ADDR = 2'b10, CMD_RD_DATA = 2'b11. The SPI slave and the bench share these.
- One sub-module, spi_ram_array:
  - Parameterised MEM_DEPTH/ADDR_SIZE, 8-bit data.
  - Ports: clk, we, waddr, wdata, re, raddr, rdata; registered read.
- spi_ram holds decode, pointers, range check, auto-increment, and the tx_valid/addr_err pipeline.

Test Plan:
- Reset, then RD_ADDR 0x10, RD_DATA -> tx_valid is a single pulse 1 cycle after rx_valid; dout = value previously written at 0x10. Before any write, check only the pulse timing.
- WR_ADDR 0x2A, WR_DATA 0xC3, RD_ADDR 0x2A, RD_DATA -> dout = 8'hC3, tx_valid high exactly one cycle, addr_err stays 0.
- Pointer independence: WR_ADDR 0x05, RD_ADDR 0x07, WR_DATA 0x11, RD_DATA -> dout = mem[0x07] (not 0x11); a follow-up RD_ADDR 0x05 then RD_DATA -> 8'h11.
- AUTO_INC = 1, MEM_DEPTH = 4: WR_ADDR 3, WR_DATA 0xAA, WR_DATA 0xBB -> mem[3] = 0xAA, mem[0] = 0xBB (wrap); RD_ADDR 3 then two back-to-back RD_DATA -> tx_valid 2 consecutive cycles with 0xAA then 0xBB.
- MEM_DEPTH = 200: WR_ADDR 0xF0, WR_DATA 0x55 -> addr_err one-cycle pulse, no storage change; RD_ADDR 0xF0, RD_DATA -> dout = 0x00, tx_valid 1, addr_err 1.
- Write 0x77 at 0x01, assert rst_n low mid-cycle during an RD_DATA -> tx_valid/dout clear immediately; after release, RD_ADDR 0x01, RD_DATA -> 0x77 (storage retained, pointers back to 0).
